// File: rtl/ise_pkg.sv
// Shared definitions for the ISE image sorting engine: colour classes,
// image geometry and the record handed to the downstream sorter.
package ise_pkg;

    localparam int unsigned IMG_SIZE    = 128;
    localparam int unsigned IMG_NUM     = 32;
    localparam int unsigned PIX_PER_IMG = IMG_SIZE * IMG_SIZE;
    localparam int unsigned IDX_W       = 5;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2
    } color_e;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        color_e           color;
        logic [7:0]       avg;
    } ise_rec_t;

endpackage

// File: rtl/ise_div8.sv
// Restoring shift-subtract divider producing an 8-bit quotient in 8 cycles.
// The caller guarantees the quotient fits in 8 bits. 'done' is high in the
// cycle whose closing edge commits the last quotient bit, so the quotient
// output is final from the edge after 'done' and holds until the next start.
module ise_div8 #(
    parameter int unsigned CNT_W = 15,
    parameter int unsigned SUM_W = CNT_W + 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [7:0]       quotient
);

    logic [SUM_W-1:0] r_rem;
    logic [SUM_W-1:0] r_dvs;
    logic [2:0]       r_iter;
    logic             r_active;
    logic [7:0]       r_quot;
    logic             w_ge;

    // r_dvs holds divisor << iter, so one compare per cycle decides quotient bit iter.
    assign w_ge     = (r_rem >= r_dvs);
    assign done     = r_active && (r_iter == 3'd0);
    assign quotient = r_quot;

    // Load on start, then one restoring step per cycle from bit 7 down to bit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem    <= '0;
            r_dvs    <= '0;
            r_iter   <= '0;
            r_active <= 1'b0;
            r_quot   <= '0;
        end else if (start) begin
            r_rem    <= dividend;
            r_dvs    <= SUM_W'(divisor) << 7;
            r_iter   <= 3'd7;
            r_active <= 1'b1;
            r_quot   <= '0;
        end else if (r_active) begin
            if (w_ge) begin
                r_rem <= r_rem - r_dvs;
            end
            r_dvs  <= r_dvs >> 1;
            r_quot <= {r_quot[6:0], w_ge};
            r_iter <= r_iter - 3'd1;
            if (r_iter == 3'd0) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ise_color_accum.sv
// Pixel-stream front end: classifies each pixel by dominant channel, keeps
// per-class counts and sums, and at the end of each image emits one record
// {index, dominant class, average dominant intensity} to the sorter.
module ise_color_accum #(
    parameter int unsigned PIX_PER_IMG = ise_pkg::PIX_PER_IMG,
    parameter int unsigned CNT_W       = $clog2(PIX_PER_IMG) + 1,
    parameter int unsigned SUM_W       = CNT_W + 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [4:0]  image_in_index,
    input  logic [23:0] pixel_in,
    output logic        busy,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [4:0]  rec_index,
    output logic [1:0]  rec_color,
    output logic [7:0]  rec_avg
);

    import ise_pkg::*;

    typedef enum logic [1:0] {
        StAccum,
        StClass,
        StDiv,
        StOut
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic             r_busy;
    logic [CNT_W-1:0] r_pix_cnt;
    logic [CNT_W-1:0] r_cnt_r;
    logic [CNT_W-1:0] r_cnt_g;
    logic [CNT_W-1:0] r_cnt_b;
    logic [SUM_W-1:0] r_sum_r;
    logic [SUM_W-1:0] r_sum_g;
    logic [SUM_W-1:0] r_sum_b;
    logic [IDX_W-1:0] r_img_index;
    logic [IDX_W-1:0] r_rec_index;
    color_e           r_rec_color;

    logic [7:0]       w_red;
    logic [7:0]       w_grn;
    logic [7:0]       w_blu;
    color_e           w_pix_cls;
    logic [7:0]       w_pix_val;
    color_e           w_win_cls;
    logic [SUM_W-1:0] w_dividend;
    logic [CNT_W-1:0] w_divisor;
    logic             w_accept;
    logic             w_last;
    logic             w_handshake;
    logic             w_div_start;
    logic             w_div_done;
    logic [7:0]       w_quotient;
    ise_rec_t         w_rec;

    assign w_red = pixel_in[23:16];
    assign w_grn = pixel_in[15:8];
    assign w_blu = pixel_in[7:0];

    // busy is 0 exactly while accumulating, so it alone gates acceptance.
    assign w_accept    = in_valid && !r_busy;
    assign w_last      = w_accept && (r_pix_cnt == CNT_W'(PIX_PER_IMG - 1));
    assign w_handshake = (r_state == StOut) && rec_ready;
    assign w_div_start = (r_state == StClass);

    // Pixel class: strictly largest channel, ties resolved R > G > B.
    always_comb begin
        w_pix_cls = RED;
        w_pix_val = w_red;
        if (w_red >= w_grn && w_red >= w_blu) begin
            w_pix_cls = RED;
            w_pix_val = w_red;
        end else if (w_grn >= w_blu) begin
            w_pix_cls = GREEN;
            w_pix_val = w_grn;
        end else begin
            w_pix_cls = BLUE;
            w_pix_val = w_blu;
        end
    end

    // Image class: largest count, ties resolved R > G > B; select divider operands.
    always_comb begin
        w_win_cls = RED;
        if (r_cnt_r >= r_cnt_g && r_cnt_r >= r_cnt_b) begin
            w_win_cls = RED;
        end else if (r_cnt_g >= r_cnt_b) begin
            w_win_cls = GREEN;
        end else begin
            w_win_cls = BLUE;
        end
        w_dividend = r_sum_r;
        w_divisor  = r_cnt_r;
        unique case (w_win_cls)
            GREEN: begin
                w_dividend = r_sum_g;
                w_divisor  = r_cnt_g;
            end
            BLUE: begin
                w_dividend = r_sum_b;
                w_divisor  = r_cnt_b;
            end
            default: ;
        endcase
    end

    // Per-class counters and sums; cleared on reset and once the record is taken.
    always_ff @(posedge clk) begin
        if (reset || w_handshake) begin
            r_pix_cnt   <= '0;
            r_cnt_r     <= '0;
            r_cnt_g     <= '0;
            r_cnt_b     <= '0;
            r_sum_r     <= '0;
            r_sum_g     <= '0;
            r_sum_b     <= '0;
            r_img_index <= '0;
        end else if (w_accept) begin
            r_pix_cnt <= r_pix_cnt + CNT_W'(1);
            if (r_pix_cnt == '0) begin
                r_img_index <= image_in_index;
            end
            unique case (w_pix_cls)
                RED: begin
                    r_cnt_r <= r_cnt_r + CNT_W'(1);
                    r_sum_r <= r_sum_r + SUM_W'(w_pix_val);
                end
                GREEN: begin
                    r_cnt_g <= r_cnt_g + CNT_W'(1);
                    r_sum_g <= r_sum_g + SUM_W'(w_pix_val);
                end
                BLUE: begin
                    r_cnt_b <= r_cnt_b + CNT_W'(1);
                    r_sum_b <= r_sum_b + SUM_W'(w_pix_val);
                end
                default: ;
            endcase
        end
    end

    // Capture index and class when the winner is chosen; they hold through OUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rec_index <= '0;
            r_rec_color <= RED;
        end else if (r_state == StClass) begin
            r_rec_index <= r_img_index;
            r_rec_color <= w_win_cls;
        end
    end

    // FSM next state.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StAccum: if (w_last) w_state_next = StClass;
            StClass: w_state_next = StDiv;
            StDiv:   if (w_div_done) w_state_next = StOut;
            StOut:   if (rec_ready) w_state_next = StAccum;
            default: w_state_next = StAccum;
        endcase
    end

    // State register and registered busy (high in every non-accumulating state).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StAccum;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != StAccum);
        end
    end

    ise_div8 #(
        .CNT_W (CNT_W),
        .SUM_W (SUM_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (w_div_start),
        .dividend (w_dividend),
        .divisor  (w_divisor),
        .done     (w_div_done),
        .quotient (w_quotient)
    );

    assign w_rec     = '{index: r_rec_index, color: r_rec_color, avg: w_quotient};
    assign busy      = r_busy;
    assign rec_valid = (r_state == StOut);
    assign rec_index = w_rec.index;
    assign rec_color = w_rec.color;
    assign rec_avg   = w_rec.avg;

endmodule
